// File: rtl/demux_1to4_tdm_pkg.sv
// Shared definitions for the 1-to-4 TDM demultiplexer.
// Build option: DEMUX_PARITY_EN adds a fifth (even parity) slot to each frame.
package demux_1to4_tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned ERR_W  = 3;

`ifdef DEMUX_PARITY_EN
    localparam int unsigned FRAME_LEN = NUM_CH + 1;
`else
    localparam int unsigned FRAME_LEN = NUM_CH;
`endif

    // Slots held back until the completing beat arrives
    localparam int unsigned SHADOW_W = FRAME_LEN - 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);

endpackage

// File: rtl/demux_1to4_tdm_slot_tracker.sv
// tdm_slot_tracker: slot counting, frame-sync checking and lock FSM.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_valid          beat qualifier
//   frame_sync        marks slot-0 beat
//   par_fail_c        parity verdict for the completing beat (from top)
//   slot              slot expected on the next beat (registered)
//   lock              high while LOCKED (registered)
//   sync_err          one-cycle framing error pulse (registered)
//   store_c           this beat's bit is kept at index slot
//   capture_c         this beat starts a new frame as slot 0
//   complete_c        this beat is the last slot of a frame
// Build option: DEMUX_PARITY_EN (via package frame length).
module tdm_slot_tracker
    import demux_1to4_tdm_pkg::*;
#(
    parameter int unsigned SYNC_LOSS_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              frame_sync,
    input  logic              par_fail_c,
    output logic [SLOT_W-1:0] slot,
    output logic              lock,
    output logic              sync_err,
    output logic              store_c,
    output logic              capture_c,
    output logic              complete_c
);

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [ERR_W-1:0]   err_inc;
    logic               sync_err_d;

    assign err_inc = err_q + ERR_W'(1);

    // State, slot, error counter and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            slot     <= '0;
            err_q    <= '0;
            lock     <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot     <= slot_d;
            err_q    <= err_d;
            lock     <= (state_d == LOCKED);
            sync_err <= sync_err_d;
        end
    end

    // Next-state and per-beat decisions
    always_comb begin
        state_d    = state_q;
        slot_d     = slot;
        err_d      = err_q;
        sync_err_d = 1'b0;
        store_c    = 1'b0;
        capture_c  = 1'b0;
        complete_c = 1'b0;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        capture_c = 1'b1;
                        store_c   = 1'b1;
                        slot_d    = SLOT_W'(1);
                        err_d     = '0;
                        state_d   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot == '0) begin
                        if (frame_sync) begin
                            capture_c = 1'b1;
                            store_c   = 1'b1;
                            slot_d    = SLOT_W'(1);
                        end else begin
                            // Expected sync never came: give up the frame alignment
                            sync_err_d = 1'b1;
                            slot_d     = '0;
                            err_d      = '0;
                            state_d    = HUNT;
                        end
                    end else if (frame_sync) begin
                        // Early sync: resync on it unless too many in a row
                        sync_err_d = 1'b1;
                        if (err_inc >= ERR_W'(SYNC_LOSS_LIMIT)) begin
                            slot_d  = '0;
                            err_d   = '0;
                            state_d = HUNT;
                        end else begin
                            err_d     = err_inc;
                            capture_c = 1'b1;
                            store_c   = 1'b1;
                            slot_d    = SLOT_W'(1);
                        end
                    end else begin
                        store_c = 1'b1;
                        if (slot == LAST_SLOT) begin
                            complete_c = 1'b1;
                            slot_d     = '0;
                            // A parity-rejected frame leaves the error count alone
                            if (!par_fail_c) begin
                                err_d = '0;
                            end
                        end else begin
                            slot_d = slot + SLOT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                    err_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/demux_1to4_tdm.sv
// demux_1to4_tdm: serial TDM bit stream to a 4-channel parallel word.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in, in_valid      serial data bit and beat qualifier
//   frame_sync        marks the slot-0 beat
//   out, out_valid    last complete frame (out[n] = channel n), update pulse
//   lock              high while aligned to frames
//   slot              slot index expected on the next beat
//   sync_err          framing error pulse
//   par_err           parity error pulse (always 0 unless DEMUX_PARITY_EN)
// Build option: DEMUX_PARITY_EN -- 5-slot frames, slot 4 is even parity.
module demux_1to4_tdm
    import demux_1to4_tdm_pkg::*;
#(
    parameter int unsigned SYNC_LOSS_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in,
    input  logic              in_valid,
    input  logic              frame_sync,
    output logic [NUM_CH-1:0] out,
    output logic              out_valid,
    output logic              lock,
    output logic [SLOT_W-1:0] slot,
    output logic              sync_err,
    output logic              par_err
);

    logic [SHADOW_W-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0]   frame_bits_c;
    logic                par_fail_c;
    logic                store_c;
    logic                capture_c;
    logic                complete_c;

    tdm_slot_tracker #(
        .SYNC_LOSS_LIMIT (SYNC_LOSS_LIMIT)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .frame_sync (frame_sync),
        .par_fail_c (par_fail_c),
        .slot       (slot),
        .lock       (lock),
        .sync_err   (sync_err),
        .store_c    (store_c),
        .capture_c  (capture_c),
        .complete_c (complete_c)
    );

    // Frame word and parity verdict for the completing beat
`ifdef DEMUX_PARITY_EN
    assign frame_bits_c = shadow_q;
    assign par_fail_c   = ^{in, shadow_q};
`else
    assign frame_bits_c = {in, shadow_q};
    assign par_fail_c   = 1'b0;
`endif

    // Shadow update: a capture restarts the frame at bit 0
    always_comb begin
        shadow_d = shadow_q;
        if (capture_c) begin
            shadow_d = SHADOW_W'(in);
        end else if (store_c) begin
            for (int i = 0; i < int'(SHADOW_W); i++) begin
                if (slot == SLOT_W'(i)) begin
                    shadow_d[i] = in;
                end
            end
        end
    end

    // Shadow, output word and result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            out_valid <= complete_c && !par_fail_c;
            par_err   <= complete_c && par_fail_c;
            if (complete_c && !par_fail_c) begin
                out <= frame_bits_c;
            end
        end
    end

endmodule

// File: tb/tb_demux_1to4_tdm.sv
// Testbench for demux_1to4_tdm: directed scenarios plus random beats,
// checked by a scoreboard against a frame-level reference model.
// Build option: DEMUX_PARITY_EN selects the 5-slot frame in both bench and DUT.
module tb_demux_1to4_tdm;

    localparam int LIMIT = 2;
`ifdef DEMUX_PARITY_EN
    localparam int FL  = 5;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = 4;
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] kind;   // {out_valid, sync_err, par_err}
        logic [3:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in;
    logic       in_valid;
    logic       frame_sync;
    logic [3:0] out;
    logic       out_valid;
    logic       lock;
    logic [2:0] slot;
    logic       sync_err;
    logic       par_err;

    int   total = 0;
    int   bad   = 0;

    // Reference model: pos<0 means hunting, otherwise next slot in frame
    int         pos  = -1;
    int         errs = 0;
    logic [4:0] fr   = '0;
    logic [3:0] m_out = '0;
    ev_t        q[$];

    demux_1to4_tdm #(
        .SYNC_LOSS_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .in_valid   (in_valid),
        .frame_sync (frame_sync),
        .out        (out),
        .out_valid  (out_valid),
        .lock       (lock),
        .slot       (slot),
        .sync_err   (sync_err),
        .par_err    (par_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_beat(input logic fs, input logic b);
        ev_t e;
        if (pos < 0) begin
            if (fs) begin
                fr = '0;
                fr[0] = b;
                pos = 1;
                errs = 0;
            end
        end else if (fs) begin
            if (pos == 0) begin
                fr[0] = b;
                pos = 1;
            end else begin
                e.kind = 3'b010; e.data = '0; q.push_back(e);
                errs++;
                if (errs >= LIMIT) begin
                    pos = -1;
                    errs = 0;
                end else begin
                    fr[0] = b;
                    pos = 1;
                end
            end
        end else if (pos == 0) begin
            e.kind = 3'b010; e.data = '0; q.push_back(e);
            pos = -1;
            errs = 0;
        end else begin
            fr[pos] = b;
            if (pos == FL - 1) begin
                if (!PAR || (^fr) == 1'b0) begin
                    m_out = fr[3:0];
                    e.kind = 3'b100; e.data = fr[3:0]; q.push_back(e);
                    errs = 0;
                end else begin
                    e.kind = 3'b001; e.data = '0; q.push_back(e);
                end
                pos = 0;
            end else begin
                pos++;
            end
        end
    endtask

    task automatic drive(input logic v, input logic fs, input logic b);
        @(posedge clk);
        #2;
        in_valid = v;
        frame_sync = fs;
        in = b;
        if (v) model_beat(fs, b);
    endtask

    task automatic model_reset();
        q.delete();
        pos = -1;
        errs = 0;
        fr = '0;
        m_out = '0;
    endtask

    task automatic send_frame(input logic [3:0] d, input bit gap);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, d[i]);
            if (gap) begin
                drive(1'b0, 1'b0, 1'b0);
                chk("gap_slot_hold", 32'(slot), 32'((i + 1) % FL));
            end
        end
        if (PAR) drive(1'b1, 1'b0, ^d);
    endtask

    // Monitor: every cycle compare status against the model and pop the scoreboard
    initial begin
        ev_t e;
        logic [2:0] exp_k;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                chk("lock", 32'(lock), 32'(pos >= 0));
                chk("slot", 32'(slot), 32'((pos < 0) ? 0 : pos));
                chk("out", 32'(out), 32'(m_out));
                exp_k = 3'b000;
                if (q.size() != 0) begin
                    e = q.pop_front();
                    exp_k = e.kind;
                    if (e.kind == 3'b100) chk("frame_data", 32'(out), 32'(e.data));
                end
                chk("pulses", 32'({out_valid, sync_err, par_err}), 32'(exp_k));
            end
        end
    end

    initial begin
        logic fs;
        logic b;
        logic v;
        rst_n = 1'b0;
        in = 1'b0;
        in_valid = 1'b0;
        frame_sync = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_lock", 32'(lock), 32'h0);
        chk("rst_slot", 32'(slot), 32'h0);
        chk("rst_pulses", 32'({out_valid, sync_err, par_err}), 32'h0);
        #1;
        rst_n = 1'b1;

        // Locked frame 0,1,0,1
        drive(1'b0, 1'b0, 1'b0);
        send_frame(4'b1010, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("frame_1010", 32'(out), 32'h a);
        chk("frame_1010_valid", 32'(out_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b0);
        chk("valid_one_cycle", 32'(out_valid), 32'h0);

        // Gapped frame 1,1,0,1
        send_frame(4'b1011, 1'b1);
        chk("gapped_1011", 32'(out), 32'h b);

        // Good frame then missing sync at slot 0
        send_frame(4'b1110, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("frame_1110", 32'(out), 32'h e);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("miss_sync_err", 32'(sync_err), 32'h1);
        chk("miss_sync_lock", 32'(lock), 32'h0);
        chk("miss_sync_out_held", 32'(out), 32'h e);

        // Misplaced sync at slot 2, twice
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("early_sync1_err", 32'(sync_err), 32'h1);
        chk("early_sync1_lock", 32'(lock), 32'h1);
        chk("early_sync1_slot", 32'(slot), 32'h1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("early_sync2_err", 32'(sync_err), 32'h1);
        chk("early_sync2_lock", 32'(lock), 32'h0);
        chk("early_sync2_slot", 32'(slot), 32'h0);

`ifdef DEMUX_PARITY_EN
        // Parity: good then bad parity on data 0010
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("par_good_out", 32'(out), 32'h2);
        chk("par_good_valid", 32'(out_valid), 32'h1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("par_bad_err", 32'(par_err), 32'h1);
        chk("par_bad_valid", 32'(out_valid), 32'h0);
        chk("par_bad_out_held", 32'(out), 32'h2);
`endif

        // Reset mid-frame after two beats
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        frame_sync = 1'b0;
        in = 1'b0;
        model_reset();
        #1;
        chk("midrst_out", 32'(out), 32'h0);
        chk("midrst_lock", 32'(lock), 32'h0);
        chk("midrst_slot", 32'(slot), 32'h0);
        chk("midrst_pulses", 32'({out_valid, sync_err, par_err}), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Random beats, sync mostly at frame boundaries
        for (int n = 0; n < 1500; n++) begin
            v  = ($urandom % 4) != 0;
            fs = (pos <= 0) ? (($urandom % 100) < 85) : (($urandom % 100) < 6);
            b  = 1'($urandom);
            if (PAR && pos == FL - 1) b = (^fr[3:0]) ^ (($urandom % 8) == 0);
            drive(v, fs, b);
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
